conv_pad_sequencer: RTL and testbench
=====================================

Name: conv_pad_sequencer

Overview:
- Front-end controller for the 3x3 convolution core. It accepts an unpadded 512-wide grayscale frame of run-time height from an upstream valid/ready source.
- It emits the zero-padded stream the core expects: (H+2) rows of 514 beats, with one zero border on every side.
- It latches the filter coefficients once per frame and holds them stable for the whole frame.
- It reports busy, last-beat and frame-done status to the system.

Parameters:
- IMAGE_WIDTH, 512, unpadded pixels per row.
- PIXEL_DATAW, 8, pixel and coefficient width.
- FILTER_SIZE, 3, filter dimension; pad width is (FILTER_SIZE-1)/2 = 1.
- HEIGHT_W, 16, width of the frame-height field.

Ports:
- clk  in  1  operating clock.
- reset  in  1  reset, synchronous, active-high.
- i_start  in  1  frame start request; sampled only in IDLE.
- i_height  in  HEIGHT_W  unpadded row count H; sampled together with i_start.
- i_f  in  72  nine signed coefficients, row-major; sampled together with i_start.
- i_valid  in  1  upstream pixel valid.
- i_x  in  8  upstream pixel.
- o_ready  out  1  upstream may transfer.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream (core) ready.
- o_y  out  8  padded-stream pixel.
- o_f  out  72  latched coefficients driven to the core.
- o_last  out  1  final beat of the frame, qualified by o_valid.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Reset values: state IDLE; all counters 0; o_f 0; o_valid 0; o_ready 0; o_y 0; o_last 0; o_busy 0; o_done 0.
- States:
  - IDLE to PAD_TOP on i_start with i_height != 0. On that edge, latch i_f into o_f and latch H.
  - PAD_TOP to BODY after 514 zero beats transfer.
  - BODY to PAD_BOT after H rows transfer.
  - PAD_BOT to IDLE after 514 zero beats transfer; o_done pulses on the next cycle.
- i_start with i_height == 0 is ignored (state stays IDLE). i_start outside IDLE is ignored.
- Transfer definition: a beat transfers when o_valid && i_ready.
- Column counter: runs 0..513, advances only on a transfer, wraps to 0. Row counter advances on each wrap.
- BODY row structure: col 0 and col 513 are pad beats (o_valid=1, o_y=0). Cols 1..512 are pass-through beats.
- Pass-through beats are zero latency, combinational:
  - o_valid = i_valid;
  - o_y = i_x;
  - o_ready = i_ready.
- On pad beats and in PAD_TOP/PAD_BOT: o_ready = 0 and o_valid = 1.
- In IDLE: o_ready = 0 and o_valid = 0.
- Backpressure: when i_ready = 0, counters and state hold. On pad beats o_valid stays 1 with o_y = 0.
- o_last is 1 only in PAD_BOT at col 513.
- o_busy = (state != IDLE).
- o_f is stable from the start edge until the next accepted start. It is never modified mid-frame.
- Total beats per frame = (H+2)*514. Row counter is HEIGHT_W+1 bits; H = 65535 must not overflow.
- A reset asserted mid-frame returns the block to IDLE on the next edge. Partial-frame data is dropped and o_done is not pulsed.
- The last transfer of PAD_BOT and an i_start in the same cycle: the start is ignored (state is not yet IDLE).

Optional Feature:
- Macro CONV_PAD_SEQ_STATS_EN.
- Defined:
  - adds output o_frame_cnt (16 bit): frames completed, incremented with o_done, wraps at 65535 to 0.
  - adds output o_stall_cnt (32 bit): cycles with o_busy && o_valid && !i_ready, cleared on each accepted i_start, saturating.
  - both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package conv_pkg:
  - constants IMAGE_WIDTH, PAD_W, PADDED_WIDTH = IMAGE_WIDTH+2*PAD_W, PIXEL_DATAW, FILTER_SIZE;
  - typedef enum seq_state_t {IDLE, PAD_TOP, BODY, PAD_BOT};
  - typedef coef_vec_t (72-bit packed coefficient vector).
- One sub-module, conv_rc_counter: enable-gated column counter (0..PADDED_WIDTH-1) with row carry, terminal-count flags and synchronous clear.

Test Plan:
- H=1, i_ready=1, i_valid=1, pixels 1..512: exactly 1542 beats. Beats 1-515 are 0, beats 516-1027 are 1..512 (mod 256), beats 1028-1542 are 0. o_last on beat 1542; o_done one cycle later.
- Backpressure: H=2, toggle i_ready every cycle. Beat sequence is identical to the no-stall case; o_y and o_valid hold while stalled.
- Upstream bubbles: H=1, i_valid low for 5 cycles at col 100. o_valid=0 and no counter advance during the bubble; o_ready=0 during all pad beats.
- i_start with i_f=0x01..09 mid-frame: o_f unchanged. i_start with i_height=0 in IDLE: o_busy stays 0.
- Reset at beat 600 of an H=4 frame: next cycle IDLE, o_valid=0, o_done never pulses. A new H=1 frame then produces 1542 beats correctly.
- With CONV_PAD_SEQ_STATS_EN, 3 back-to-back H=1 frames: o_frame_cnt=3. o_stall_cnt equals the number of injected i_ready-low cycles in the last frame.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and types for the convolution pad sequencer
package conv_pkg;

    localparam int IMAGE_WIDTH  = 512;
    localparam int FILTER_SIZE  = 3;
    localparam int PAD_W        = (FILTER_SIZE - 1) / 2;
    localparam int PADDED_WIDTH = IMAGE_WIDTH + 2 * PAD_W;
    localparam int PIXEL_DATAW  = 8;
    localparam int HEIGHT_W     = 16;
    localparam int COL_W        = $clog2(PADDED_WIDTH);
    // One extra bit so a 65535-row frame plus both pad rows still fits.
    localparam int ROW_W        = HEIGHT_W + 1;
    localparam int COEF_W       = FILTER_SIZE * FILTER_SIZE * PIXEL_DATAW;

    typedef enum logic [1:0] {
        IDLE,
        PAD_TOP,
        BODY,
        PAD_BOT
    } seq_state_t;

    typedef logic [COEF_W-1:0] coef_vec_t;

endpackage

// File: rtl/conv_rc_counter.sv
// rtl/conv_rc_counter.sv - padded column counter with row carry and synchronous clear
module conv_rc_counter
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_first,
    output logic             col_last
);

    assign col_first = (col == '0);
    assign col_last  = (col == COL_W'(PADDED_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_pad_sequencer.sv
// rtl/conv_pad_sequencer.sv - zero-pad frame sequencer for the 3x3 core; optional stats via CONV_PAD_SEQ_STATS_EN
module conv_pad_sequencer
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [HEIGHT_W-1:0]    i_height,
    input  coef_vec_t              i_f,
    input  logic                   i_valid,
    input  logic [PIXEL_DATAW-1:0] i_x,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [PIXEL_DATAW-1:0] o_y,
    output coef_vec_t              o_f,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done
`ifdef CONV_PAD_SEQ_STATS_EN
    ,
    output logic [15:0]            o_frame_cnt,
    output logic [31:0]            o_stall_cnt
`endif
);

    seq_state_t          state, state_nxt;
    logic [HEIGHT_W-1:0] height_q;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                col_first, col_last;
    logic                xfer, row_wrap, frame_end, start_ok, cnt_clr;

    assign start_ok  = (state == IDLE) && i_start && (i_height != '0);
    assign row_wrap  = xfer && col_last;
    assign frame_end = (state == PAD_BOT) && row_wrap;
    assign cnt_clr   = start_ok || frame_end;
    assign o_busy    = (state != IDLE);

    conv_rc_counter u_rc_counter (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (xfer),
        .col       (col),
        .row       (row),
        .col_first (col_first),
        .col_last  (col_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            height_q <= '0;
            o_f      <= '0;
            o_done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= frame_end;
            if (start_ok) begin
                height_q <= i_height;
                o_f      <= i_f;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        o_valid   = 1'b0;
        o_ready   = 1'b0;
        o_y       = '0;
        o_last    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = PAD_TOP;
            end
            PAD_TOP: begin
                o_valid = 1'b1;
            end
            BODY: begin
                // Border columns are generated locally; the rest is a wire-through.
                if (col_first || col_last) begin
                    o_valid = 1'b1;
                end else begin
                    o_valid = i_valid;
                    o_y     = i_x;
                    o_ready = i_ready;
                end
            end
            PAD_BOT: begin
                o_valid = 1'b1;
                o_last  = col_last;
            end
            default: state_nxt = IDLE;
        endcase

        xfer = o_valid && i_ready;

        case (state)
            PAD_TOP: if (xfer && col_last) state_nxt = BODY;
            BODY:    if (xfer && col_last && (row == {1'b0, height_q})) state_nxt = PAD_BOT;
            PAD_BOT: if (xfer && col_last) state_nxt = IDLE;
            default: ;
        endcase
    end

`ifdef CONV_PAD_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_frame_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (frame_end) o_frame_cnt <= o_frame_cnt + 1'b1;
            if (start_ok) begin
                o_stall_cnt <= '0;
            end else if (o_busy && o_valid && !i_ready && (o_stall_cnt != '1)) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_pad_sequencer.sv
// tb/tb_conv_pad_sequencer.sv - self-checking bench for conv_pad_sequencer
module tb_conv_pad_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [15:0] i_height;
    logic [71:0] i_f;
    logic        i_valid;
    logic [7:0]  i_x;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_y;
    logic [71:0] o_f;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
`ifdef CONV_PAD_SEQ_STATS_EN
    logic [15:0] o_frame_cnt;
    logic [31:0] o_stall_cnt;
`endif

    always #5 clk = ~clk;

    conv_pad_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_height (i_height),
        .i_f      (i_f),
        .i_valid  (i_valid),
        .i_x      (i_x),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_y      (o_y),
        .o_f      (o_f),
        .o_last   (o_last),
        .o_busy   (o_busy),
        .o_done   (o_done)
`ifdef CONV_PAD_SEQ_STATS_EN
        ,
        .o_frame_cnt (o_frame_cnt),
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    localparam int ROW_BEATS = 514;
    localparam int MAX_PIX   = 2048;

    typedef struct {
        int h;
        int rmode;      // 0 always ready, 1 toggle, 2 random
        int vmode;      // 0 always valid, 1 five-cycle bubble at col 100, 2 random
        int start_mode; // 0 none, 1 start mid-frame, 2 start on the final beat
        int pattern;    // 1 = pixels 1..N, 0 = random
        int exp_beats;
    } frame_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pix [0:MAX_PIX-1];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Padded frame: border rows/cols are zero, interior is raster-ordered input pixels.
    function automatic bit is_pad(input int idx, input int h);
        int r, c;
        r = idx / ROW_BEATS;
        c = idx % ROW_BEATS;
        return (r == 0) || (r == h + 1) || (c == 0) || (c == ROW_BEATS - 1);
    endfunction

    function automatic logic [7:0] exp_beat(input int idx, input int h);
        int r, c;
        r = idx / ROW_BEATS;
        c = idx % ROW_BEATS;
        if (is_pad(idx, h)) return 8'h00;
        return pix[(r - 1) * 512 + (c - 1)];
    endfunction

    task automatic run_frame(input int h, input int rmode, input int vmode, input int rst_beat,
                             input int start_mode, input logic [71:0] coef,
                             output int beats, output int stalls);
        int  total;
        int  idx;
        int  up;
        int  cyc;
        int  bubble;
        bit  tog;
        bit  bubbled;
        bit  aborted;
        bit  pad;
        total   = (h + 2) * ROW_BEATS;
        idx     = 0;
        up      = 0;
        cyc     = 0;
        bubble  = 0;
        tog     = 1'b0;
        bubbled = 1'b0;
        aborted = 1'b0;
        stalls  = 0;

        @(posedge clk); #1;
        i_start  = 1'b1;
        i_height = h[15:0];
        i_f      = coef;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_after_start", 72'(o_busy), 72'(1));
        check("o_f_latched", o_f, coef);

        while (idx < total && cyc < 20000 && !aborted) begin
            i_start = 1'b0;
            case (rmode)
                0:       i_ready = 1'b1;
                1:       begin i_ready = tog; tog = ~tog; end
                default: i_ready = ($urandom_range(0, 3) != 0);
            endcase
            case (vmode)
                0: i_valid = 1'b1;
                1: begin
                    if (!bubbled && idx == ROW_BEATS + 100) begin
                        bubble  = 5;
                        bubbled = 1'b1;
                    end
                    i_valid = (bubble == 0);
                    if (bubble > 0) bubble--;
                end
                default: i_valid = ($urandom_range(0, 3) != 0);
            endcase
            i_x = pix[(up < MAX_PIX) ? up : MAX_PIX - 1];
            if (start_mode == 1 && idx == 700) begin
                i_start  = 1'b1;
                i_height = 16'd1;
                i_f      = 72'h010203040506070809;
            end
            if (start_mode == 2 && idx == total - 1) begin
                i_start  = 1'b1;
                i_height = 16'd1;
                i_ready  = 1'b1;
            end
            if (rst_beat >= 0 && idx == rst_beat) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset   = 1'b0;
                i_valid = 1'b0;
                i_ready = 1'b0;
                check("rst_mid_busy", 72'(o_busy), 72'(0));
                check("rst_mid_valid", 72'(o_valid), 72'(0));
                check("rst_mid_ready", 72'(o_ready), 72'(0));
                check("rst_mid_last", 72'(o_last), 72'(0));
                repeat (5) begin
                    @(posedge clk); #1;
                    check("no_done_after_reset", 72'(o_done), 72'(0));
                end
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                pad = is_pad(idx, h);
                if (pad) begin
                    check("pad_valid", 72'(o_valid), 72'(1));
                    check("pad_ready", 72'(o_ready), 72'(0));
                end else begin
                    check("pass_valid", 72'(o_valid), 72'(i_valid));
                    check("pass_ready", 72'(o_ready), 72'(i_ready));
                end
                if (o_valid && i_ready) begin
                    check("beat_y", 72'(o_y), 72'(exp_beat(idx, h)));
                    check("beat_last", 72'(o_last), 72'(idx == total - 1));
                end else if (o_valid && pad) begin
                    check("stall_pad_y", 72'(o_y), 72'(0));
                end
                if (o_valid && !i_ready) stalls++;
                if (i_valid && o_ready) up++;
                if (o_valid && i_ready) idx++;
                cyc++;
                @(posedge clk); #1;
                if (idx < total) check("done_low_mid_frame", 72'(o_done), 72'(0));
            end
        end

        if (!aborted) begin
            if (idx < total) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle_budget: got %0d beats expected %0d", idx, total);
            end
            i_start = 1'b0;
            check("done_pulse", 72'(o_done), 72'(1));
            check("idle_after_frame", 72'(o_busy), 72'(0));
            check("valid_after_frame", 72'(o_valid), 72'(0));
            check("o_f_held", o_f, coef);
            @(posedge clk); #1;
            check("done_one_cycle", 72'(o_done), 72'(0));
            check("still_idle", 72'(o_busy), 72'(0));
        end
        beats = idx;
    endtask

    frame_vec_t vecs [0:4];
    int beats;
    int stalls;
    logic [71:0] coef;

    initial begin
        vecs[0] = '{h: 1, rmode: 0, vmode: 0, start_mode: 0, pattern: 1, exp_beats: 1542};
        vecs[1] = '{h: 2, rmode: 1, vmode: 0, start_mode: 0, pattern: 0, exp_beats: 2056};
        vecs[2] = '{h: 1, rmode: 0, vmode: 1, start_mode: 0, pattern: 0, exp_beats: 1542};
        vecs[3] = '{h: 3, rmode: 2, vmode: 2, start_mode: 1, pattern: 0, exp_beats: 2570};
        vecs[4] = '{h: 1, rmode: 2, vmode: 2, start_mode: 2, pattern: 0, exp_beats: 1542};

        reset    = 1'b1;
        i_start  = 1'b0;
        i_height = '0;
        i_f      = '0;
        i_valid  = 1'b0;
        i_x      = '0;
        i_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 72'(o_busy), 72'(0));
        check("rst_valid", 72'(o_valid), 72'(0));
        check("rst_ready", 72'(o_ready), 72'(0));
        check("rst_y", 72'(o_y), 72'(0));
        check("rst_last", 72'(o_last), 72'(0));
        check("rst_done", 72'(o_done), 72'(0));
        check("rst_f", o_f, 72'(0));
        reset = 1'b0;

        // Zero-height start must be ignored.
        @(posedge clk); #1;
        i_start  = 1'b1;
        i_height = 16'd0;
        i_f      = 72'hA5A5A5A5A5A5A5A5A5;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("h0_busy", 72'(o_busy), 72'(0));
        check("h0_f_unlatched", o_f, 72'(0));

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < MAX_PIX; i++)
                pix[i] = (vecs[v].pattern != 0) ? 8'(i + 1) : 8'($urandom);
            coef = {$urandom, $urandom, $urandom};
            run_frame(vecs[v].h, vecs[v].rmode, vecs[v].vmode, -1, vecs[v].start_mode, coef, beats, stalls);
            check($sformatf("vec%0d_beats", v), 72'(beats), 72'(vecs[v].exp_beats));
        end

        // Mid-frame reset, then a clean frame.
        for (int i = 0; i < MAX_PIX; i++) pix[i] = 8'($urandom);
        run_frame(4, 0, 0, 600, 0, 72'h123456789ABCDEF012, beats, stalls);
        check("rst_frame_beats_at_reset", 72'(beats), 72'(600));
        run_frame(1, 2, 2, -1, 0, 72'h0F0E0D0C0B0A090807, beats, stalls);
        check("post_rst_beats", 72'(beats), 72'(1542));

`ifdef CONV_PAD_SEQ_STATS_EN
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("stats_rst_frames", 72'(o_frame_cnt), 72'(0));
        check("stats_rst_stalls", 72'(o_stall_cnt), 72'(0));
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < MAX_PIX; i++) pix[i] = 8'($urandom);
            run_frame(1, (f == 2) ? 2 : 0, 0, -1, 0, {$urandom, $urandom, $urandom}, beats, stalls);
        end
        check("stats_frames", 72'(o_frame_cnt), 72'(3));
        check("stats_stalls", 72'(o_stall_cnt), 72'(stalls));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
